// File: rtl/mist_io_pkg.sv
// Shared command bytes and upload-FSM state encoding for the host I/O blocks.
package mist_io_pkg;
    localparam logic [7:0] MIST_CMD_RX     = 8'h60;
    localparam logic [7:0] MIST_CMD_RX_DAT = 8'h61;
    localparam logic [7:0] MIST_CMD_INDEX  = 8'h55;

    typedef enum logic [1:0] {
        ST_CMD       = 2'd0,
        ST_PARAM_RX  = 2'd1,
        ST_PARAM_IDX = 2'd2,
        ST_STREAM    = 2'd3
    } up_state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronisers for SCK/SS/MOSI plus SCK edge detect; edges are 2-3 clk behind the pins.
// No backpressure: one-cycle edge pulses, SCK must stay at or below clk_sys/4.
module spi_sync_edge (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic spi_sck,
    input  logic spi_ss,
    input  logic spi_di,
    output logic sck_rise,
    output logic sck_fall,
    output logic ss_s,
    output logic di_s
);
    logic sck_meta_q, sck_sync_q, sck_prev_q;
    logic ss_meta_q, ss_sync_q;
    logic di_meta_q, di_sync_q;

    // Chip select resets high so the block starts deselected.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sck_meta_q <= 1'b0;
            sck_sync_q <= 1'b0;
            sck_prev_q <= 1'b0;
            ss_meta_q  <= 1'b1;
            ss_sync_q  <= 1'b1;
            di_meta_q  <= 1'b0;
            di_sync_q  <= 1'b0;
        end else begin
            sck_meta_q <= spi_sck;
            sck_sync_q <= sck_meta_q;
            sck_prev_q <= sck_sync_q;
            ss_meta_q  <= spi_ss;
            ss_sync_q  <= ss_meta_q;
            di_meta_q  <= spi_di;
            di_sync_q  <= di_meta_q;
        end
    end

    assign sck_rise = sck_sync_q & ~sck_prev_q;
    assign sck_fall = ~sck_sync_q & sck_prev_q;
    assign ss_s     = ss_sync_q;
    assign di_s     = di_sync_q;
endmodule

// File: rtl/spi_upload.sv
// Streams host-selected memory out on MISO: command decode, one-byte prefetch buffer, MSB-first shifter.
// A fetch issues 1 clk after each byte load, one toggle fetch outstanding; late data shifts stale and sets underrun.
module spi_upload
    import mist_io_pkg::*;
#(
    parameter int unsigned AW         = 25,
    parameter logic [7:0]  CMD_RX     = MIST_CMD_RX,
    parameter logic [7:0]  CMD_RX_DAT = MIST_CMD_RX_DAT,
    parameter logic [7:0]  CMD_INDEX  = MIST_CMD_INDEX
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          SPI_SCK,
    input  logic          SPI_SS2,
    input  logic          SPI_DI,
    output logic          SPI_DO,
    output logic          ioctl_upload,
    output logic [7:0]    ioctl_index,
    output logic [AW-1:0] ioctl_addr,
    output logic          mem_req,
    input  logic          mem_ack,
    input  logic [7:0]    ioctl_din,
    output logic          underrun
);
    logic sck_rise, sck_fall, ss_s, di_s;

    spi_sync_edge u_sync (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .spi_sck  (SPI_SCK),
        .spi_ss   (SPI_SS2),
        .spi_di   (SPI_DI),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .ss_s     (ss_s),
        .di_s     (di_s)
    );

    up_state_t     state_q, state_d;
    logic          cmd_done_q, cmd_done_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [6:0]    rx_sr_q, rx_sr_d;
    logic [7:0]    tx_sr_q, tx_sr_d;
    logic [7:0]    buf_q, buf_d;
    logic          buf_vld_q, buf_vld_d;
    logic          upload_q, upload_d;
    logic [7:0]    index_q, index_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          req_q, req_d;
    logic          busy_q, busy_d;
    logic          want_q, want_d;
    logic          underrun_q, underrun_d;

    logic          fetch_done;
    logic [7:0]    rx_byte;

    assign fetch_done = busy_q && (mem_ack == req_q);
    assign rx_byte    = {rx_sr_q, di_s};

    always_comb begin
        state_d    = state_q;
        cmd_done_d = cmd_done_q;
        bit_cnt_d  = bit_cnt_q;
        rx_sr_d    = rx_sr_q;
        tx_sr_d    = tx_sr_q;
        buf_d      = buf_q;
        buf_vld_d  = buf_vld_q;
        upload_d   = upload_q;
        index_d    = index_q;
        addr_d     = addr_q;
        req_d      = req_q;
        busy_d     = busy_q;
        want_d     = want_q;
        underrun_d = underrun_q;

        if (fetch_done) begin
            buf_d     = ioctl_din;
            buf_vld_d = 1'b1;
            busy_d    = 1'b0;
        end
        // A queued fetch leaves as soon as the previous one has been acknowledged.
        if (want_q && (mem_ack == req_q)) begin
            req_d  = ~req_q;
            busy_d = 1'b1;
            want_d = 1'b0;
        end

        if (ss_s) begin
            bit_cnt_d  = 3'd0;
            state_d    = ST_CMD;
            cmd_done_d = 1'b0;
            tx_sr_d    = 8'h00;
        end else if (sck_rise) begin
            rx_sr_d   = {rx_sr_q[5:0], di_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                case (state_q)
                    ST_CMD: begin
                        if (!cmd_done_q) begin
                            cmd_done_d = 1'b1;
                            if (rx_byte == CMD_RX)
                                state_d = ST_PARAM_RX;
                            else if (rx_byte == CMD_INDEX)
                                state_d = ST_PARAM_IDX;
                            else if (rx_byte == CMD_RX_DAT && upload_q)
                                state_d = ST_STREAM;
                        end
                    end
                    ST_PARAM_IDX: begin
                        index_d = rx_byte;
                        state_d = ST_CMD;
                    end
                    ST_PARAM_RX: begin
                        state_d = ST_CMD;
                        if (rx_byte != 8'h00) begin
                            upload_d   = 1'b1;
                            addr_d     = '0;
                            underrun_d = 1'b0;
                            buf_vld_d  = 1'b0;
                            want_d     = 1'b1;
                        end else begin
                            upload_d = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end else if (sck_fall && state_q == ST_STREAM) begin
            if (bit_cnt_q == 3'd0) begin
                // Data landing this very cycle beats the stale buffer.
                tx_sr_d = fetch_done ? ioctl_din : buf_q;
                if (!buf_vld_q && !fetch_done)
                    underrun_d = 1'b1;
                buf_vld_d = 1'b0;
                addr_d    = addr_q + AW'(1);
                want_d    = 1'b1;
            end else begin
                tx_sr_d = {tx_sr_q[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_CMD;
            cmd_done_q <= 1'b0;
            bit_cnt_q  <= 3'd0;
            rx_sr_q    <= 7'd0;
            tx_sr_q    <= 8'h00;
            buf_q      <= 8'h00;
            buf_vld_q  <= 1'b0;
            upload_q   <= 1'b0;
            index_q    <= 8'h00;
            addr_q     <= '0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            want_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_done_q <= cmd_done_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_sr_q    <= rx_sr_d;
            tx_sr_q    <= tx_sr_d;
            buf_q      <= buf_d;
            buf_vld_q  <= buf_vld_d;
            upload_q   <= upload_d;
            index_q    <= index_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            busy_q     <= busy_d;
            want_q     <= want_d;
            underrun_q <= underrun_d;
        end
    end

    assign SPI_DO       = tx_sr_q[7];
    assign ioctl_upload = upload_q;
    assign ioctl_index  = index_q;
    assign ioctl_addr   = addr_q;
    assign mem_req      = req_q;
    assign underrun     = underrun_q;
endmodule

// File: tb/tb_spi_upload.sv
// Bench for spi_upload: SPI host tasks, delayed toggle-handshake memory responder, byte-stream reference model.
module tb_spi_upload;
    localparam int AW = 25;

    logic          clk_sys = 1'b0;
    logic          reset_n;
    logic          SPI_SCK, SPI_SS2, SPI_DI;
    logic          SPI_DO;
    logic          ioctl_upload;
    logic [7:0]    ioctl_index;
    logic [AW-1:0] ioctl_addr;
    logic          mem_req;
    logic          mem_ack = 1'b0;
    logic [7:0]    ioctl_din = 8'h00;
    logic          underrun;

    spi_upload #(.AW(AW)) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .SPI_SCK      (SPI_SCK),
        .SPI_SS2      (SPI_SS2),
        .SPI_DI       (SPI_DI),
        .SPI_DO       (SPI_DO),
        .ioctl_upload (ioctl_upload),
        .ioctl_index  (ioctl_index),
        .ioctl_addr   (ioctl_addr),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .ioctl_din    (ioctl_din),
        .underrun     (underrun)
    );

    always #5 clk_sys = ~clk_sys;

    logic [7:0]  mem [256];
    int          ack_delay;
    int          fetch_cnt = 0;
    int          resp_cnt;
    logic        resp_pend = 1'b0;
    logic [7:0]  resp_addr;
    int          half;
    int          n_checks, n_pass;
    logic [7:0]  rxq [$];

    // Memory responder: notices a request toggle, waits ack_delay cycles, then answers.
    always @(negedge clk_sys) begin
        if (!reset_n) begin
            mem_ack   = 1'b0;
            resp_pend = 1'b0;
        end else if (resp_pend) begin
            if (resp_cnt == 0) begin
                ioctl_din = mem[resp_addr];
                mem_ack   = mem_req;
                resp_pend = 1'b0;
            end else begin
                resp_cnt--;
            end
        end else if (mem_req != mem_ack) begin
            resp_pend = 1'b1;
            resp_cnt  = ack_delay;
            resp_addr = ioctl_addr[7:0];
            fetch_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic ss_begin();
        SPI_SS2 = 1'b0;
        tick(half);
    endtask

    // Each bit begins with a falling edge; MISO is read at the end of the high phase.
    task automatic xbits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nb; i++) begin
            SPI_SCK = 1'b0;
            SPI_DI  = tx[7-i];
            tick(half);
            SPI_SCK = 1'b1;
            tick(half);
            rx[7-i] = SPI_DO;
        end
    endtask

    // Deselect while SCK is still high so no trailing falling edge starts another byte.
    task automatic ss_end();
        SPI_SS2 = 1'b1;
        tick(half + 2);
        SPI_SCK = 1'b0;
        tick(half + 4);
    endtask

    task automatic send2(input logic [7:0] b0, input logic [7:0] b1);
        logic [7:0] r;
        ss_begin();
        xbits(b0, 8, r);
        xbits(b1, 8, r);
        ss_end();
    endtask

    task automatic stream(input int nb);
        logic [7:0] r;
        rxq.delete();
        ss_begin();
        xbits(8'h61, 8, r);
        for (int i = 0; i < nb; i++) begin
            xbits(8'h00, 8, r);
            rxq.push_back(r);
        end
        ss_end();
    endtask

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] prm;
        logic [7:0] exp_idx;
        logic       exp_up;
        int         exp_fetch;
    } vec_t;

    vec_t       vt [8];
    int         f0, k, nb, op;
    logic [7:0] mref_idx, r, v;

    initial begin
        reset_n = 1'b0; SPI_SS2 = 1'b1; SPI_SCK = 1'b0; SPI_DI = 1'b0;
        half = 4; ack_delay = 0; n_checks = 0; n_pass = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        vt[0] = '{8'h55, 8'h07, 8'h07, 1'b0, 0};
        vt[1] = '{8'h55, 8'hC3, 8'hC3, 1'b0, 0};
        vt[2] = '{8'h42, 8'h11, 8'hC3, 1'b0, 0};
        vt[3] = '{8'h61, 8'h00, 8'hC3, 1'b0, 0};
        vt[4] = '{8'h60, 8'h01, 8'hC3, 1'b1, 1};
        vt[5] = '{8'h60, 8'h00, 8'hC3, 1'b0, 0};
        vt[6] = '{8'h60, 8'h80, 8'hC3, 1'b1, 1};
        vt[7] = '{8'h55, 8'h00, 8'h00, 1'b1, 0};

        tick(3);
        check("rst_do", SPI_DO, 0);
        check("rst_upload", ioctl_upload, 0);
        check("rst_index", ioctl_index, 0);
        check("rst_addr", ioctl_addr, 0);
        check("rst_req", mem_req, 0);
        check("rst_underrun", underrun, 0);
        reset_n = 1'b1;
        tick(4);

        for (int i = 0; i < 8; i++) begin
            f0 = fetch_cnt;
            send2(vt[i].cmd, vt[i].prm);
            tick(10);
            check($sformatf("vec%0d_index", i), ioctl_index, vt[i].exp_idx);
            check($sformatf("vec%0d_upload", i), ioctl_upload, vt[i].exp_up);
            check($sformatf("vec%0d_addr", i), ioctl_addr, 0);
            check($sformatf("vec%0d_fetches", i), fetch_cnt - f0, vt[i].exp_fetch);
        end

        // Start with a responder answering A5h.
        mem[0] = 8'hA5;
        f0 = fetch_cnt;
        send2(8'h60, 8'hFF);
        tick(10);
        check("start_upload", ioctl_upload, 1);
        check("start_addr", ioctl_addr, 0);
        check("start_fetches", fetch_cnt - f0, 1);
        stream(1);
        check("start_byte", rxq[0], 8'hA5);
        check("start_addr_after", ioctl_addr, 1);

        // Stream from memory[n] = n ^ 5Ah.
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        send2(8'h60, 8'hFF);
        tick(10);
        stream(4);
        check("stream_b0", rxq[0], 8'h5A);
        check("stream_b1", rxq[1], 8'h5B);
        check("stream_b2", rxq[2], 8'h58);
        check("stream_b3", rxq[3], 8'h59);
        check("stream_addr", ioctl_addr, 4);
        check("stream_underrun", underrun, 0);

        // A byte cut short by deselect is lost; the next stream resumes at the buffered byte.
        ss_begin();
        xbits(8'h61, 8, r);
        xbits(8'h00, 3, r);
        ss_end();
        stream(1);
        check("resume_byte", rxq[0], 8'h5F);
        check("resume_addr", ioctl_addr, 6);

        // Randomised sessions against the byte-sequence model.
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
        ack_delay = $urandom_range(0, 3);
        send2(8'h60, 8'hFF);
        tick(10);
        k = 0;
        mref_idx = ioctl_index;
        for (int it = 0; it < 12; it++) begin
            half = $urandom_range(2, 6);
            op = $urandom_range(0, 2);
            if (op == 0) begin
                v = 8'($urandom_range(0, 255));
                mref_idx = v;
                send2(8'h55, v);
                check($sformatf("rnd%0d_index", it), ioctl_index, mref_idx);
            end else if (op == 1) begin
                v = 8'($urandom_range(0, 255));
                if (v == 8'h55 || v == 8'h60 || v == 8'h61) v = 8'h3E;
                send2(v, 8'($urandom_range(0, 255)));
                check($sformatf("rnd%0d_junk_index", it), ioctl_index, mref_idx);
                check($sformatf("rnd%0d_junk_upload", it), ioctl_upload, 1);
            end else begin
                nb = $urandom_range(1, 4);
                stream(nb);
                for (int j = 0; j < nb; j++) begin
                    check($sformatf("rnd%0d_byte%0d", it, j), rxq[j], mem[k]);
                    k++;
                end
                check($sformatf("rnd%0d_addr", it), ioctl_addr, k);
                check($sformatf("rnd%0d_underrun", it), underrun, 0);
            end
        end

        // Slow memory at SCK = clk/4: second byte repeats the stale buffer.
        half = 2;
        ack_delay = 200;
        tick(20);
        send2(8'h60, 8'hFF);
        tick(260);
        stream(2);
        check("under_b0", rxq[0], mem[0]);
        check("under_b1", rxq[1], mem[0]);
        check("under_flag", underrun, 1);
        check("under_addr", ioctl_addr, 2);
        tick(600);
        ack_delay = 0;
        half = 4;

        // Stop, then a data-stream command must not stream.
        send2(8'h60, 8'h00);
        check("stop_upload", ioctl_upload, 0);
        stream(1);
        check("stop_no_data", rxq[0], 8'h00);
        check("stop_addr", ioctl_addr, 2);

        // Asynchronous reset in the middle of a streamed byte.
        send2(8'h55, 8'h3C);
        send2(8'h60, 8'hFF);
        tick(10);
        ss_begin();
        xbits(8'h61, 8, r);
        xbits(8'h00, 5, r);
        @(negedge clk_sys);
        #2 reset_n = 1'b0;
        #1;
        check("arst_do", SPI_DO, 0);
        check("arst_upload", ioctl_upload, 0);
        check("arst_index", ioctl_index, 0);
        check("arst_addr", ioctl_addr, 0);
        check("arst_req", mem_req, 0);
        check("arst_underrun", underrun, 0);
        SPI_SS2 = 1'b1;
        SPI_SCK = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(4);
        send2(8'h55, 8'h81);
        check("post_rst_index", ioctl_index, 8'h81);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/spi_upload.md
SPI_UPLOAD -- requirements
Module: spi_upload

Interface
REQ-001 Parameter AW, default 25: width of ioctl_addr.
REQ-002 Parameter CMD_RX, default 8'h60: upload start/stop command byte.
REQ-003 Parameter CMD_RX_DAT, default 8'h61: upload data-stream command byte.
REQ-004 Parameter CMD_INDEX, default 8'h55: set-index command byte.
REQ-005 Port clk_sys  in  1: sole clock. Every register is clocked on its rising edge.
REQ-006 Port reset_n  in  1: asynchronous, active-low reset.
REQ-007 Port SPI_SCK  in  1: host SPI clock, asynchronous to clk_sys.
REQ-008 Port SPI_SS2  in  1: host chip select, active-low, asynchronous.
REQ-009 Port SPI_DI  in  1: host MOSI, asynchronous.
REQ-010 Port SPI_DO  out  1: MISO, driven MSB-first.
REQ-011 Port ioctl_upload  out  1: upload session active.
REQ-012 Port ioctl_index  out  8: file index last set by the host.
REQ-013 Port ioctl_addr  out  AW: byte address of the current fetch.
REQ-014 Port mem_req  out  1: toggle-type fetch request.
REQ-015 Port mem_ack  in  1: toggle-type fetch acknowledge; data is valid when mem_ack equals mem_req.
REQ-016 Port ioctl_din  in  8: fetched byte, sampled in the cycle mem_ack first equals mem_req.
REQ-017 Port underrun  out  1: sticky flag, a byte was shifted out before its fetch completed.

Function
REQ-018 SPI_SCK, SPI_SS2 and SPI_DI shall each pass through a 2-flop synchroniser; edges are detected on the synchronised SCK. SCK ≤ clk_sys/4 is guaranteed.
REQ-019 While SS2 is high: bit counter = 0, state = CMD, SPI_DO = 0.
REQ-020 MOSI shall be sampled on SCK rising edges; 8 bits form a byte, MSB first.
REQ-021 States: CMD, PARAM_RX, PARAM_IDX, STREAM.
REQ-022 In CMD, transitions by first byte received after SS2 falls: CMD_RX -> PARAM_RX; CMD_INDEX -> PARAM_IDX; CMD_RX_DAT -> STREAM, only if ioctl_upload = 1, otherwise stay in CMD; any other byte -> stay in CMD.
REQ-023 PARAM_IDX: the next byte is loaded into ioctl_index.
REQ-024 PARAM_RX, byte != 0: ioctl_upload <= 1, ioctl_addr <= 0, underrun <= 0, and one fetch is issued (mem_req toggles).
REQ-025 PARAM_RX, byte == 0: ioctl_upload <= 0; no fetch is issued.
REQ-026 A fetch completion shall load ioctl_din into a 1-byte buffer and set buffer-valid.
REQ-027 STREAM, on the SCK falling edge that begins each byte: the shifter loads the buffer, and SPI_DO = buffer[7]. Further falling edges shift left.
REQ-028 If buffer-valid = 0 when a STREAM byte begins, the stale buffer shall be shifted anyway and underrun set.
REQ-029 After a STREAM byte load: buffer-valid <= 0, ioctl_addr increments by 1, and a new fetch is issued 1 cycle after the load.
REQ-030 ioctl_addr shall wrap modulo 2^AW.
REQ-031 At most one fetch shall be outstanding; a new fetch waits until mem_ack == mem_req.
REQ-032 SS2 rising mid-byte: the partial byte is discarded. ioctl_upload, ioctl_addr and the pending fetch are unaffected, and the next CMD_RX_DAT resumes at the current buffer.
REQ-033 If a fetch completion and a STREAM byte load fall in the same cycle, the load takes the newly fetched byte, and buffer-valid ends at 0.

Reset
REQ-034 With reset_n low, asynchronously: SPI_DO = 0, ioctl_upload = 0, ioctl_index = 0, ioctl_addr = 0, mem_req = 0, underrun = 0, buffer = 0, buffer-valid = 0, state = CMD, synchronisers = 1 for SS2 and 0 otherwise.
REQ-035 Reset asserted mid-fetch abandons the fetch. After reset, mem_req = 0; the responder must also be reset so that mem_ack = 0.

Structure
REQ-036 Command byte constants and the state enum shall live in a shared package, mist_io_pkg.
REQ-037 One sub-module, spi_sync_edge, shall hold the synchroniser and edge detect.

Verification
REQ-038 Index: SS2 low, send 55h,07h -> ioctl_index = 07h; ioctl_upload stays 0.
REQ-039 Start: send 60h,FFh -> ioctl_upload = 1, ioctl_addr = 0, one mem_req toggle; responder returns A5h.
REQ-040 Stream: with memory[n] = n^5Ah, send 61h then clock 4 bytes -> MISO reads 5Ah,5Bh,58h,59h; ioctl_addr = 4; underrun = 0.
REQ-041 Underrun: responder ack delayed 200 cycles, SCK = clk/4, stream 2 bytes -> underrun = 1, second byte equals the first.
REQ-042 Stop/reset: send 60h,00h -> ioctl_upload = 0. Pulse reset_n mid-byte -> all outputs return to REQ-034 values within the same cycle.
